shift_reg_ctrl: RTL and testbench
=================================

Name: shift_reg_ctrl

Overview:
- Transmit sequencer for the N-bit parallel-load shift register.
- Accepts parallel words over a valid/ready handshake and drives the register's load_en/load/en/din pins to serialize each word MSB-first.
- Qualifies the serial stream with ser_valid, pulses done per word, and inserts a programmable idle gap between words.
- Sits between a word source (FIFO or CPU register) and the shift_reg instance.

Parameters:
- N, 4, word width; must match the attached shift register's N (N >= 2).
- GAP, 1, idle cycles after done before in_ready reasserts (0 allowed).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- res  in  1  reset, asynchronous, active-high.
- in_valid  in  1  source presents a word.
- in_data  in  N  word to transmit.
- in_ready  out  1  controller can accept a word this cycle.
- abort  in  1  synchronous abort of the frame in flight.
- sr_load_en  out  1  to shift register load_en.
- sr_load  out  N  to shift register load.
- sr_en  out  1  to shift register en.
- sr_din  out  1  to shift register din; fill bit, constant 0.
- sr_dout  in  1  from shift register dout; the current MSB.
- ser_out  out  1  serial bit; sr_dout gated by ser_valid, else 0.
- ser_valid  out  1  ser_out carries a frame bit this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last frame bit.

Behaviour:
- Reset values (asserted immediately, asynchronously):
  - state=IDLE.
  - in_ready=0, sr_load_en=0, sr_load=0, sr_en=0, ser_valid=0, busy=0, done=0, bit counter=0.
- in_ready rises on the first clk edge after res deasserts.
- All control outputs are registered. ser_out is combinational from sr_dout and ser_valid.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - Handshake at edge with in_valid&&in_ready: capture in_data into sr_load, set sr_load_en=1, in_ready=0, go to LOAD.
  - No handshake: remain in IDLE.
- LOAD (1 cycle):
  - sr_load_en=1; the shift register loads at the closing edge.
  - Then sr_load_en=0, sr_en=1, ser_valid=1, counter=0, go to SHIFT.
- SHIFT (N cycles):
  - In cycle k (k=0..N-1), ser_out is bit N-1-k of the captured word.
  - sr_en=1 every cycle; the counter increments per edge.
  - At the edge ending cycle N-1: sr_en=0, ser_valid=0, done=1 for the next cycle, go to GAP. If GAP=0, go directly to IDLE with in_ready=1 in the same cycle as done.
- GAP:
  - Hold for GAP cycles (counter reused), then go to IDLE.
  - done is high only in the first GAP cycle.
- Latency:
  - Handshake edge t0; first data bit on ser_out in cycle t0+2 (after the LOAD cycle).
  - Last bit in t0+N+1; done in t0+N+2.
  - Next handshake possible at edge ending cycle t0+N+2+GAP.
  - Back-to-back throughput is one word per N+2+GAP cycles.
- Boundaries:
  - in_valid while in_ready=0 is ignored; the source holds data.
  - in_data changes after the handshake do not affect the frame in flight.
  - Counter width is $clog2(N+2) bits (>= GAP width by localparam max). No wrap occurs inside a frame.
- abort:
  - In LOAD or SHIFT at an edge: next cycle IDLE, all outputs at idle values, done not pulsed, word dropped. The shift register contents are left stale.
  - In GAP: jump to IDLE at that edge.
  - In IDLE: no effect; a simultaneous handshake still wins.
- Reset mid-frame: immediate return to reset values, no done, word lost.

Optional Feature:
- Macro: SHIFT_REG_CTRL_PARITY_EN.
- Defined:
  - SHIFT lasts N+1 cycles.
  - In cycle N: sr_en=0, ser_valid=1, ser_out = even parity (XOR) of the captured word, held in a register computed at capture.
  - done moves one cycle later.
  - Throughput is N+3+GAP cycles per word.
- Undefined: no parity logic, timing as above.

Test Plan:
- Reset then word 4'b1011 with in_valid held one cycle -> ser_out 1,0,1,1 on cycles t0+2..t0+5 with ser_valid=1; done pulses at t0+6; in_ready returns at t0+7 (GAP=1).
- Back-to-back 4'b0101 then 4'b1100 with in_valid held high -> second handshake exactly 7 cycles after first; serial 0101 then 1100; exactly two done pulses.
- abort asserted during SHIFT bit 2 of 4'b1111 -> next cycle busy=0, ser_valid=0, in_ready=1; no done pulse.
- res asserted mid-SHIFT (async, between edges) -> all outputs 0 immediately; after release, in_ready=1 on the next edge and a new word 4'b0011 serializes correctly.
- in_data toggled to 4'bxxxx after handshake of 4'b1001 -> ser_out still 1,0,0,1; no X on ser_out while ser_valid=0.
- With SHIFT_REG_CTRL_PARITY_EN, word 4'b1011 -> bits 1,0,1,1 then parity 1 with ser_valid=1; done at t0+7.

Source files
------------

// File: rtl/shift_reg_ctrl.sv
// -----------------------------------------------------------------------------
// shift_reg_ctrl
//
// Transmit sequencer for an N-bit parallel-load shift register. It accepts
// words over a valid/ready handshake. It loads each word into the external
// register and shifts it out MSB-first, and it qualifies the serial stream
// with ser_valid. It pulses done once per completed word, then holds off the
// next word for GAP idle cycles.
//
// Frame timeline for a handshake at the edge that closes cycle t0:
//   t0+1               LOAD  (sr_load_en high; the register loads at its end)
//   t0+2 .. t0+N+1     SHIFT (ser_out = word[N-1] .. word[0])
//   t0+N+2             done pulse (first GAP cycle, or IDLE when GAP == 0)
//   t0+N+2+GAP         in_ready high again
//
// Optional build macro: SHIFT_REG_CTRL_PARITY_EN
//   When defined, SHIFT gains one extra cycle that carries the even parity
//   (XOR) of the captured word on ser_out, and every later event moves one
//   cycle later.
//
// Reset: res is asynchronous and active-high.
// -----------------------------------------------------------------------------
module shift_reg_ctrl #(
    parameter int N   = 4,  // word width; must match the attached shift register
    parameter int GAP = 1   // idle cycles after done before in_ready reasserts
) (
    input  logic         clk,
    input  logic         res,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    input  logic         abort,
    output logic         sr_load_en,
    output logic [N-1:0] sr_load,
    output logic         sr_en,
    output logic         sr_din,
    input  logic         sr_dout,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         busy,
    output logic         done
);

    // The counter has to reach the last SHIFT index and the last GAP index.
    localparam int SHIFT_W = $clog2(N + 2);
    localparam int GAP_W   = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int CNT_W   = (SHIFT_W > GAP_W) ? SHIFT_W : GAP_W;

`ifdef SHIFT_REG_CTRL_PARITY_EN
    // The extra parity cycle sits at counter value N.
    localparam int SHIFT_END = N;
`else
    localparam int SHIFT_END = N - 1;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_END);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next values of the registered outputs.
    logic             in_ready_nxt;
    logic             load_en_nxt;
    logic [N-1:0]     load_nxt;
    logic             en_nxt;
    logic             valid_nxt;
    logic             busy_nxt;
    logic             done_nxt;

`ifdef SHIFT_REG_CTRL_PARITY_EN
    logic             parity_q;
    logic             parity_nxt;
    logic             par_phase;
    logic             par_phase_nxt;
`endif

    // The fill bit shifted into the register is always zero.
    assign sr_din = 1'b0;

    // Serial output: the register MSB (or the parity bit) gated by ser_valid.
`ifdef SHIFT_REG_CTRL_PARITY_EN
    assign ser_out = ser_valid & (par_phase ? parity_q : sr_dout);
`else
    assign ser_out = ser_valid & sr_dout;
`endif

    // State register and bit counter.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and next-output decode.
    // NOTE: every variable gets a default at the top of the block, so no path
    // can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        load_nxt     = sr_load;
        in_ready_nxt = 1'b0;
        load_en_nxt  = 1'b0;
        en_nxt       = 1'b0;
        valid_nxt    = 1'b0;
        done_nxt     = 1'b0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
        parity_nxt    = parity_q;
        par_phase_nxt = 1'b0;
`endif

        case (state)
            ST_IDLE: begin
                // in_ready is held low for one cycle after reset. The
                // handshake therefore uses the registered value, not the
                // state alone. abort has no effect here.
                in_ready_nxt = 1'b1;
                if (in_valid && in_ready) begin
                    state_nxt    = ST_LOAD;
                    load_nxt     = in_data;
                    load_en_nxt  = 1'b1;
                    in_ready_nxt = 1'b0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
                    parity_nxt   = ^in_data;
`endif
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    state_nxt    = ST_IDLE;
                    in_ready_nxt = 1'b1;
                end else begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = '0;
                    en_nxt    = 1'b1;
                    valid_nxt = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    // The word is dropped. The register keeps stale contents.
                    state_nxt    = ST_IDLE;
                    in_ready_nxt = 1'b1;
                end else if (cnt == SHIFT_LAST) begin
                    done_nxt = 1'b1;
                    if (GAP == 0) begin
                        state_nxt    = ST_IDLE;
                        in_ready_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                    valid_nxt = 1'b1;
`ifdef SHIFT_REG_CTRL_PARITY_EN
                    if (cnt == DATA_LAST) begin
                        // The next cycle carries parity, so the register stays still.
                        par_phase_nxt = 1'b1;
                    end else begin
                        en_nxt = 1'b1;
                    end
`else
                    en_nxt = (cnt != DATA_LAST);
`endif
                end
            end

            ST_GAP: begin
                if (abort || (cnt == GAP_LAST)) begin
                    state_nxt    = ST_IDLE;
                    in_ready_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt    = ST_IDLE;
                in_ready_nxt = 1'b1;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // Registered control outputs, so no glitches reach the shift register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            in_ready   <= 1'b0;
            sr_load_en <= 1'b0;
            sr_load    <= '0;
            sr_en      <= 1'b0;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            in_ready   <= in_ready_nxt;
            sr_load_en <= load_en_nxt;
            sr_load    <= load_nxt;
            sr_en      <= en_nxt;
            ser_valid  <= valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

`ifdef SHIFT_REG_CTRL_PARITY_EN
    // Parity of the captured word, and the flag that marks the parity cycle.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            parity_q  <= 1'b0;
            par_phase <= 1'b0;
        end else begin
            parity_q  <= parity_nxt;
            par_phase <= par_phase_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_ctrl
//
// Directed scenarios followed by randomized traffic. The monitor keeps a
// cycle-stamped model of the expected serial bits, done pulses and in_ready
// timing. It derives this model from the frame latency rules: bits at t0+2+k,
// done after the last bit, and in_ready GAP cycles after done. A behavioural
// shift register closes the loop on sr_dout.
// -----------------------------------------------------------------------------
module tb_shift_reg_ctrl;

    localparam int N   = 4;
    localparam int GAP = 1;
`ifdef SHIFT_REG_CTRL_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic         clk = 1'b0;
    logic         res;
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_ready;
    logic         abort;
    logic         sr_load_en;
    logic [N-1:0] sr_load;
    logic         sr_en;
    logic         sr_din;
    logic         sr_dout;
    logic         ser_out;
    logic         ser_valid;
    logic         busy;
    logic         done;

    shift_reg_ctrl #(.N(N), .GAP(GAP)) dut (
        .clk        (clk),
        .res        (res),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .abort      (abort),
        .sr_load_en (sr_load_en),
        .sr_load    (sr_load),
        .sr_en      (sr_en),
        .sr_din     (sr_din),
        .sr_dout    (sr_dout),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Behavioural model of the attached parallel-load shift register.
    logic [N-1:0] sr_q = '0;
    always @(posedge clk) begin
        if (sr_load_en)
            sr_q <= sr_load;
        else if (sr_en)
            sr_q <= {sr_q[N-2:0], sr_din};
    end
    assign sr_dout = sr_q[N-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        logic val;
        int   at;
    } exp_bit_t;

    exp_bit_t bit_q[$];
    int       done_q[$];
    int       exp_ready  = -1;
    bit       ready_model = 1'b0;
    bit       busy_model  = 1'b0;
    bit       res_seen    = 1'b0;

    always @(negedge clk) begin
        if (res) begin
            bit_q.delete();
            done_q.delete();
            exp_ready   = -1;
            ready_model = 1'b0;
            busy_model  = 1'b0;
            res_seen    = 1'b1;
        end else begin
            bit exp_v;
            bit exp_d;
            if (res_seen) begin
                exp_ready = cyc + 1;
                res_seen  = 1'b0;
            end
            if (cyc == exp_ready) begin
                ready_model = 1'b1;
                busy_model  = 1'b0;
            end
            check("in_ready", in_ready, ready_model);
            check("busy", busy, busy_model);

            exp_v = (bit_q.size() > 0) && (bit_q[0].at == cyc);
            check("ser_valid", ser_valid, exp_v);
            if (exp_v) begin
                check("ser_out", ser_out, bit_q[0].val);
                void'(bit_q.pop_front());
            end else if (!ser_valid) begin
                check("ser_out_idle", ser_out, 1'b0);
            end

            exp_d = (done_q.size() > 0) && (done_q[0] == cyc);
            check("done", done, exp_d);
            if (exp_d) void'(done_q.pop_front());

            // An abort during a frame or its gap drops the word and returns to idle next cycle.
            if (abort && busy_model) begin
                bit_q.delete();
                done_q.delete();
                exp_ready = cyc + 1;
            end

            // A handshake at the upcoming edge schedules the whole frame.
            if (in_valid && ready_model) begin
                for (int k = N - 1; k >= 0; k--)
                    bit_q.push_back('{val: in_data[k], at: cyc + 2 + (N - 1 - k)});
                if (P != 0)
                    bit_q.push_back('{val: ^in_data, at: cyc + 2 + N});
                done_q.push_back(cyc + N + 2 + P);
                exp_ready   = cyc + N + 2 + GAP + P;
                ready_model = 1'b0;
                busy_model  = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic send_word(input logic [N-1:0] d, input bit keep_valid, output int t0);
        bit hs = 1'b0;
        t0       = -1;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 100 && !hs; k++) begin
            @(negedge clk);
            if (in_ready) begin
                hs = 1'b1;
                t0 = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!hs) check("handshake_timeout", 32'd0, 32'd1);
        if (!keep_valid) in_valid = 1'b0;
        in_data = N'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        for (int k = 0; k < 100 && cyc != c; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_sr_load_en"}, sr_load_en, 1'b0);
        check({tag, "_sr_load"}, sr_load, '0);
        check({tag, "_sr_en"}, sr_en, 1'b0);
        check({tag, "_ser_valid"}, ser_valid, 1'b0);
        check({tag, "_ser_out"}, ser_out, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        int  t0;
        int  t1;
        bit  hs_prev;
        bit  idle_ok;

        res      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        abort    = 1'b0;
        wait_cycles(2);
        check_reset_outputs("reset");
        res = 1'b0;
        wait_cycles(2);

        // Single word with in_valid held one cycle.
        send_word(4'b1011, 1'b0, t0);
        wait_cycles(10);

        // Back-to-back words with in_valid held high.
        send_word(4'b0101, 1'b1, t0);
        send_word(4'b1100, 1'b0, t1);
        check("b2b_spacing", t1 - t0, N + 2 + GAP + P);
        wait_cycles(10);

        // Abort during SHIFT bit 2.
        send_word(4'b1111, 1'b0, t0);
        if (t0 >= 0) begin
            wait_until(t0 + 4);
            abort = 1'b1;
            wait_cycles(1);
            abort = 1'b0;
        end
        wait_cycles(6);

        // Abort in IDLE together with a handshake: the handshake wins.
        abort = 1'b1;
        send_word(4'b0110, 1'b0, t0);
        abort = 1'b0;
        wait_cycles(10);

        // Asynchronous reset in the middle of SHIFT.
        send_word(4'b0110, 1'b0, t0);
        if (t0 >= 0) begin
            wait_until(t0 + 3);
            #2;
            res = 1'b1;
            #1;
            check_reset_outputs("midreset");
            wait_cycles(2);
            res = 1'b0;
        end
        send_word(4'b0011, 1'b0, t0);
        wait_cycles(10);

        // in_data changes after the handshake must not affect the frame.
        send_word(4'b1001, 1'b0, t0);
        for (int k = 0; k < 6; k++) begin
            in_data = N'($urandom);
            wait_cycles(1);
        end
        wait_cycles(4);

        // Randomized traffic with occasional aborts.
        hs_prev = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || hs_prev) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = N'($urandom);
            end
            abort = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            hs_prev = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        abort    = 1'b0;

        // Drain: every scheduled bit and done must have been consumed.
        idle_ok = 1'b0;
        for (int k = 0; k < 60 && !idle_ok; k++) begin
            wait_cycles(1);
            idle_ok = (bit_q.size() == 0) && (done_q.size() == 0) && !busy_model;
        end
        check("drain_complete", idle_ok, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
